prog_loader: RTL and testbench

Byte-stream program loader: the writer side of the program memory that the core otherwise only reads. Accepts a framed image ("ASRM" magic, length, payload, XOR checksum) on a valid/ready byte interface, writes the payload into program RAM from address 0, and holds the CPU in reset until a valid image is stored. Sits between the debug UART receiver and the program RAM write port.

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants, state encoding and length helper for the program loader
package prog_loader_pkg;

    localparam logic [7:0] MAGIC_0 = 8'h41;
    localparam logic [7:0] MAGIC_1 = 8'h53;
    localparam logic [7:0] MAGIC_2 = 8'h52;
    localparam logic [7:0] MAGIC_3 = 8'h4D;

    localparam int DEFAULT_ADDR_WIDTH = 7;

    typedef enum logic [3:0] {
        ST_MAGIC0,
        ST_MAGIC1,
        ST_MAGIC2,
        ST_MAGIC3,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_e;

    // Largest image the program RAM can hold, in bytes
    function automatic int max_len(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream writer for program RAM; holds the CPU in reset until a good image lands
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_write_en,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int MAX_LEN = max_len(ADDR_WIDTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            rem_q, rem_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_data_q, mem_data_d;
    logic                  we_q, we_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;

    assign in_ready     = (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign xfer         = in_valid && in_ready;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_write_en = we_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        we_d        = 1'b0;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        if (start) begin
            // Any byte offered alongside start is swallowed here
            state_d     = ST_MAGIC0;
            addr_d      = '0;
            rem_d       = '0;
            csum_d      = '0;
            cpu_reset_d = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                ST_MAGIC0: if (in_data == MAGIC_0) state_d = ST_MAGIC1;
                ST_MAGIC1: begin
                    if (in_data == MAGIC_1)      state_d = ST_MAGIC2;
                    else if (in_data == MAGIC_0) state_d = ST_MAGIC1;
                    else                         state_d = ST_MAGIC0;
                end
                ST_MAGIC2: begin
                    if (in_data == MAGIC_2)      state_d = ST_MAGIC3;
                    else if (in_data == MAGIC_0) state_d = ST_MAGIC1;
                    else                         state_d = ST_MAGIC0;
                end
                ST_MAGIC3: begin
                    if (in_data == MAGIC_3)      state_d = ST_LEN;
                    else if (in_data == MAGIC_0) state_d = ST_MAGIC1;
                    else                         state_d = ST_MAGIC0;
                end
                ST_LEN: begin
                    addr_d = '0;
                    csum_d = '0;
                    rem_d  = in_data;
                    if (int'({24'd0, in_data}) > MAX_LEN) begin
                        state_d     = ST_ERROR;
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else if (in_data == 8'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    we_d       = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = in_data;
                    csum_d     = csum_q ^ in_data;
                    // Counter wraps after a full-size image; harmless since no write follows
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (in_data == csum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b1;
                    end else begin
                        state_d     = ST_ERROR;
                        error_d     = 1'b1;
                        cpu_reset_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_MAGIC0;
            addr_q      <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            we_q        <= 1'b0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            we_q        <= we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a stream-parsing reference model
module tb_prog_loader;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_write_en;
    logic          cpu_reset;
    logic          done;
    logic          error;

    prog_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write_en(mem_write_en),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write capture and strobe-provenance check
    logic   xfer_seen = 1'b0;
    int     got_addr[$];
    int     got_data[$];

    always @(posedge clk) xfer_seen <= in_valid && in_ready;

    always @(negedge clk) begin
        if (mem_write_en) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(int'(mem_data));
            chk("we_after_xfer", {31'd0, xfer_seen}, 32'd1);
        end
    end

    // Reference model: find the first "ASRM" in the accepted stream, then parse length/payload/checksum
    logic [7:0] stream[$];
    int         exp_addr[$];
    int         exp_data[$];
    bit         exp_done, exp_err;

    task automatic model_run();
        int m, p, n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        m = -1;
        for (int i = 0; i + 3 < stream.size(); i++) begin
            if (stream[i] == 8'h41 && stream[i+1] == 8'h53 && stream[i+2] == 8'h52 && stream[i+3] == 8'h4D) begin
                m = i;
                break;
            end
        end
        if (m < 0) return;
        p = m + 4;
        if (p >= stream.size()) return;
        n = int'(stream[p]);
        p++;
        if (n > (1 << AW)) begin
            exp_err = 1;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (p + k >= stream.size()) return;
            exp_addr.push_back(k);
            exp_data.push_back(int'(stream[p+k]));
            x = x ^ stream[p+k];
        end
        if (p + n >= stream.size()) return;
        if (stream[p+n] == x) exp_done = 1;
        else                  exp_err  = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        chk("in_ready_when_sending", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse(input bit with_byte, input logic [7:0] b);
        start    = 1'b1;
        in_valid = with_byte;
        in_data  = b;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_error", {31'd0, error}, 32'd0);
        chk("start_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic run_stream(input string tag, input bit stall);
        foreach (stream[i]) send_byte(stream[i], stall);
        in_valid = 1'b0;
        model_run();
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, exp_done});
        chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !(exp_done || exp_err)});
        idle(2);
        chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            chk({tag, "_waddr"}, got_addr[i], exp_addr[i]);
            chk({tag, "_wdata"}, got_data[i], exp_data[i]);
        end
    endtask

    task automatic push_bytes(input logic [7:0] b[]);
        foreach (b[i]) stream.push_back(b[i]);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_mem_addr"}, {25'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_data"}, {24'd0, mem_data}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_write_en}, 32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        int         n;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("rst");

        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h03, 8'hAA, 8'h55, 8'h0F, 8'hF0});
        run_stream("nominal", 0);
        chk("nominal_last_addr", {25'd0, mem_addr}, 32'd2);
        chk("nominal_last_data", {24'd0, mem_data}, 32'h0F);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h03, 8'hAA, 8'h55, 8'h0F, 8'h00});
        run_stream("badcsum", 1);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h41, 8'h41, 8'h53, 8'h52, 8'h4D, 8'h01, 8'h7E, 8'h7E});
        run_stream("resync", 0);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h00, 8'h13, 8'h41, 8'h53, 8'h52, 8'h4D, 8'h02, 8'h12, 8'h34, 8'h26});
        run_stream("garbage", 1);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h81});
        run_stream("len81", 0);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h80});
        x = 8'h00;
        for (int i = 0; i < 128; i++) begin
            stream.push_back(8'($urandom));
            x = x ^ stream[stream.size()-1];
        end
        stream.push_back(x);
        run_stream("len80", 1);
        chk("len80_last_addr", {25'd0, mem_addr}, 32'h7F);
        start_pulse(0, 8'h00);

        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h00, 8'h00});
        run_stream("len0", 0);
        start_pulse(0, 8'h00);

        // start coincides with a 0x41: that byte must vanish, so the rest never frames
        start_pulse(1, 8'h41);
        stream.delete();
        push_bytes('{8'h53, 8'h52, 8'h4D, 8'h01, 8'h7E, 8'h7E});
        run_stream("start_drop", 0);
        start_pulse(0, 8'h00);

        // start mid-DATA, then a fresh image from address 0
        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h05, 8'h11, 8'h22});
        foreach (stream[i]) send_byte(stream[i], 0);
        idle(2);
        chk("middata_partial_writes", got_addr.size(), 2);
        start_pulse(0, 8'h00);
        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h03, 8'hAA, 8'h55, 8'h0F, 8'hF0});
        run_stream("after_start", 1);
        start_pulse(0, 8'h00);

        // asynchronous reset while a write strobe is live
        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h05, 8'h11, 8'h22});
        foreach (stream[i]) send_byte(stream[i], 0);
        in_valid = 1'b0;
        chk("prerst_we", {31'd0, mem_write_en}, 32'd1);
        #1 reset = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b1;
        got_addr.delete();
        got_data.delete();
        stream.delete();
        push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D, 8'h01, 8'h7E, 8'h7E});
        run_stream("after_rst", 0);
        start_pulse(0, 8'h00);

        for (int t = 0; t < 12; t++) begin
            stream.delete();
            repeat ($urandom_range(0, 3)) begin
                x = 8'($urandom);
                if (x == 8'h41) x = 8'h00;
                stream.push_back(x);
            end
            push_bytes('{8'h41, 8'h53, 8'h52, 8'h4D});
            n = ($urandom_range(0, 9) == 0) ? 129 + int'($urandom_range(0, 126)) : int'($urandom_range(0, 128));
            stream.push_back(8'(n));
            if (n <= 128) begin
                x = 8'h00;
                for (int i = 0; i < n; i++) begin
                    stream.push_back(8'($urandom));
                    x = x ^ stream[stream.size()-1];
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                stream.push_back(x);
            end
            run_stream("rand", 1);
            start_pulse(0, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
